// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits + odd parity, ACK check.
// Optional macro PS2_TX_RETRY_EN: one automatic retry of the same byte after a packet timeout or missing ACK.
module ps2_host_tx #(
  parameter int CLOCK_FREQUENCY   = 25000000,
  parameter int INHIBIT_US        = 120,
  parameter int START_TIMEOUT_US  = 15000,
  parameter int PACKET_TIMEOUT_US = 2000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] txData,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] errCode
);
  localparam int CYC_US  = CLOCK_FREQUENCY / 1000000;
  localparam int INH_CYC = CYC_US * INHIBIT_US;
  localparam int STO_CYC = CYC_US * START_TIMEOUT_US;
  localparam int PKT_CYC = CYC_US * PACKET_TIMEOUT_US;
  localparam int MAX_AB  = (INH_CYC > STO_CYC) ? INH_CYC : STO_CYC;
  localparam int MAX_CYC = (MAX_AB > PKT_CYC) ? MAX_AB : PKT_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] INH_LAST = TW'(INH_CYC - 1);
  localparam logic [TW-1:0] STO_LAST = TW'(STO_CYC - 1);
  localparam logic [TW-1:0] PKT_LAST = TW'(PKT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_FIRST, S_XFER, S_WAIT_RELEASE, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic [3:0]      bit_q, bit_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            dat_low_q, dat_low_d;
  logic            busy_q, busy_d;
  logic [1:0]      code_q, code_d;
  logic [1:0]      pend_q, pend_d;
  logic            clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic            fall, retry_now, clk_low, dat_low;

  // Lines idle high, so the synchronizers reset to 1 to avoid a phantom falling edge.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_TX_RETRY_EN
  logic retry_q, retry_d;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) retry_q <= 1'b0;
    else        retry_q <= retry_d;
  end

  assign retry_now = (state_q == S_ERR) && (pend_q != 2'd1) && !retry_q;
`else
  assign retry_now = 1'b0;
`endif

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_q     <= '0;
      tmr_q     <= '0;
      dat_low_q <= 1'b0;
      busy_q    <= 1'b0;
      code_q    <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      tmr_q     <= tmr_d;
      dat_low_q <= dat_low_d;
      busy_q    <= busy_d;
      code_q    <= code_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_d     = bit_q;
    tmr_d     = tmr_q;
    dat_low_d = dat_low_q;
    busy_d    = busy_q;
    code_d    = code_q;
    pend_d    = pend_q;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        dat_low_d = 1'b0;
        if (send) begin
          data_d  = txData;
          par_d   = ~^txData;
          busy_d  = 1'b1;
          tmr_d   = '0;
          bit_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == INH_LAST) begin
          dat_low_d = 1'b1;
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        tmr_d   = '0;
        state_d = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        tmr_d = tmr_q + 1'b1;
        if (fall) begin
          dat_low_d = ~data_q[0];
          bit_d     = 4'd1;
          tmr_d     = '0;
          state_d   = S_XFER;
        end else if (tmr_q == STO_LAST) begin
          pend_d    = 2'd1;
          dat_low_d = 1'b0;
          state_d   = S_ERR;
        end
      end
      S_XFER: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == PKT_LAST) begin
          pend_d    = 2'd2;
          dat_low_d = 1'b0;
          state_d   = S_ERR;
        end else if (fall) begin
          bit_d = bit_q + 4'd1;
          case (bit_q)
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7: dat_low_d = ~data_q[bit_q[2:0]];
            4'd8:             dat_low_d = ~par_q;
            4'd9:             dat_low_d = 1'b0;
            default: begin
              // Eleventh edge: the device must be pulling DAT low as its ACK.
              if (dat_s2) begin
                pend_d  = 2'd3;
                state_d = S_ERR;
              end else begin
                state_d = S_WAIT_RELEASE;
              end
            end
          endcase
        end
      end
      S_WAIT_RELEASE: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == PKT_LAST) begin
          pend_d  = 2'd2;
          state_d = S_ERR;
        end else if (clk_s2 && dat_s2) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        code_d  = 2'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef PS2_TX_RETRY_EN
        retry_d = 1'b0;
`endif
      end
      S_ERR: begin
        dat_low_d = 1'b0;
        if (retry_now) begin
          tmr_d   = '0;
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b1;
`endif
        end else begin
          code_d  = pend_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drive enables decode straight from reset-cleared registers so reset frees the bus at once.
  assign clk_low = (state_q == S_INHIBIT);
  assign dat_low = dat_low_q | (clk_low && (tmr_q == INH_LAST));
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign busy    = busy_q;
  assign done    = (state_q == S_DONE);
  assign error   = (state_q == S_ERR) && !retry_now;
  assign errCode = code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model on pulled-up lines.
// Timing parameters are scaled down so every scenario fits in a short run.
module tb_ps2_host_tx;
  localparam int CF     = 2000000;
  localparam int INH_US = 120;
  localparam int STO_US = 5000;
  localparam int PKT_US = 2000;
  localparam int INH    = CF / 1000000 * INH_US;
  localparam int STO    = CF / 1000000 * STO_US;
  localparam int HALF   = 40;

  logic       clk = 1'b0;
  logic       rst_n, send;
  logic [7:0] tx;
  logic       dev_clk_low, dev_dat_low;
  wire        ps2_clk, ps2_dat;
  logic       busy, done, error;
  logic [1:0] errCode;
  int total = 0, bad = 0, done_cnt = 0, err_cnt = 0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .CLOCK_FREQUENCY(CF), .INHIBIT_US(INH_US),
    .START_TIMEOUT_US(STO_US), .PACKET_TIMEOUT_US(PKT_US)
  ) dut (
    .Clock(clk), .reset(rst_n), .send(send), .txData(tx),
    .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .busy(busy), .done(done), .error(error), .errCode(errCode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_send(input logic [7:0] b);
    tx = b; send = 1'b1;
    tick(1);
    send = 1'b0;
  endtask

  // Counts CLK-low cycles of the inhibit, then reports DAT at the first released-CLK cycle.
  task automatic wait_rts(output int low_cyc, output logic dat_rel, output bit ok);
    int n = 0;
    ok = 1'b0; low_cyc = 0; dat_rel = 1'b1;
    while (ps2_clk !== 1'b0 && n < 1000) begin tick(1); n++; end
    if (ps2_clk !== 1'b0) return;
    while (ps2_clk === 1'b0 && low_cyc < 20000) begin low_cyc++; tick(1); end
    dat_rel = ps2_dat;
    ok = 1'b1;
  endtask

  // Device clocking: samples DAT on each rising edge; after the stop bit pulls DAT low if ack.
  task automatic dev_clock(input int nedges, input bit ack, output logic [9:0] samp);
    samp = '0;
    for (int e = 1; e <= nedges; e++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      if (e <= 10) samp[e-1] = ps2_dat;
      if (e == 11) dev_dat_low = 1'b0;
      if (e == 10) begin
        tick(HALF / 2);
        dev_dat_low = ack;
        tick(HALF - HALF / 2);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
    total++; if (errCode !== 2'd0) begin bad++; $display("FAIL reset_errcode: got %0d want 0", errCode); end
    total++; if ({ps2_clk, ps2_dat} !== 2'b11) begin bad++; $display("FAIL reset_lines: got %b want 11", {ps2_clk, ps2_dat}); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic();
    int d0 = done_cnt, e0 = err_cnt, lc;
    logic dr; bit ok; logic [9:0] s;
    do_send(8'hED);
    wait_rts(lc, dr, ok);
    total++; if (!ok || lc != INH) begin bad++; $display("FAIL inhibit_len: got %0d want %0d", lc, INH); end
    total++; if (dr !== 1'b0) begin bad++; $display("FAIL rts_dat: got %b want 0", dr); end
    tick(20);
    dev_clock(11, 1'b1, s);
    tick(10);
    total++; if (s[7:0] !== 8'hED) begin bad++; $display("FAIL basic_bits: got %h want ed", s[7:0]); end
    total++; if (s[8] !== odd_par(8'hED)) begin bad++; $display("FAIL basic_par: got %b want %b", s[8], odd_par(8'hED)); end
    total++; if (s[9] !== 1'b1) begin bad++; $display("FAIL basic_stop: got %b want 1", s[9]); end
    total++; if (done_cnt - d0 != 1 || err_cnt != e0) begin bad++; $display("FAIL basic_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
    total++; if (busy !== 1'b0 || errCode !== 2'd0) begin bad++; $display("FAIL basic_status: got busy=%b code=%0d want 0 0", busy, errCode); end
  endtask

  task automatic test_parity();
    logic [7:0] pats [7];
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h01;
    for (int i = 3; i < 7; i++) pats[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) begin
      int d0 = done_cnt, lc;
      logic dr; bit ok; logic [9:0] s;
      do_send(pats[i]);
      wait_rts(lc, dr, ok);
      tick(20);
      dev_clock(11, 1'b1, s);
      tick(10);
      total++; if (!ok || s[7:0] !== pats[i]) begin bad++; $display("FAIL par_bits[%0d]: got %h want %h", i, s[7:0], pats[i]); end
      total++; if (s[8] !== odd_par(pats[i])) begin bad++; $display("FAIL par_bit[%0d]: got %b want %b", i, s[8], odd_par(pats[i])); end
      total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL par_done[%0d]: got %0d want 1", i, done_cnt - d0); end
    end
  endtask

  task automatic test_start_timeout();
    int e0 = err_cnt, lc, cyc = 0;
    logic dr; bit ok;
    do_send(8'($urandom));
    wait_rts(lc, dr, ok);
    while (error !== 1'b1 && cyc < STO + 100) begin tick(1); cyc++; end
    total++; if (!ok || cyc < STO || cyc > STO + 2) begin bad++; $display("FAIL sto_time: got %0d want %0d..%0d", cyc, STO, STO + 2); end
    total++; if ({ps2_clk, ps2_dat} !== 2'b11) begin bad++; $display("FAIL sto_lines: got %b want 11", {ps2_clk, ps2_dat}); end
    tick(2);
    total++; if (errCode !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL sto_status: got code=%0d busy=%b want 1 0", errCode, busy); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL sto_pulses: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_nack();
    int d0 = done_cnt, e0 = err_cnt, lc;
    logic dr; bit ok; logic [9:0] s;
    do_send(8'hF4);
    wait_rts(lc, dr, ok);
    tick(20);
    dev_clock(11, 1'b0, s);
`ifdef PS2_TX_RETRY_EN
    wait_rts(lc, dr, ok);
    total++; if (!ok || lc <= 0 || lc >= INH) begin bad++; $display("FAIL retry_inhibit: got %0d want 1..%0d", lc, INH - 1); end
    total++; if (err_cnt != e0 || busy !== 1'b1) begin bad++; $display("FAIL retry_hidden: got err=%0d busy=%b want 0 1", err_cnt - e0, busy); end
    tick(20);
    dev_clock(11, 1'b1, s);
    tick(10);
    total++; if (s[7:0] !== 8'hF4) begin bad++; $display("FAIL retry_bits: got %h want f4", s[7:0]); end
    total++; if (done_cnt - d0 != 1 || errCode !== 2'd0) begin bad++; $display("FAIL retry_done: got done=%0d code=%0d want 1 0", done_cnt - d0, errCode); end
`else
    tick(10);
    total++; if (err_cnt - e0 != 1 || done_cnt != d0) begin bad++; $display("FAIL nack_pulses: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
    total++; if (errCode !== 2'd3 || busy !== 1'b0) begin bad++; $display("FAIL nack_status: got code=%0d busy=%b want 3 0", errCode, busy); end
`endif
  endtask

  task automatic test_reset_mid();
    int d0, lc;
    logic dr; bit ok; logic [9:0] s;
    do_send(8'hE0);
    wait_rts(lc, dr, ok);
    tick(20);
    dev_clock(5, 1'b1, s);
    total++; if (ps2_dat !== 1'b0) begin bad++; $display("FAIL mid_dat_driven: got %b want 0", ps2_dat); end
    rst_n = 1'b0;
    #1;
    total++; if ({ps2_clk, ps2_dat, busy} !== 3'b110) begin bad++; $display("FAIL mid_reset: got %b want 110", {ps2_clk, ps2_dat, busy}); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    d0 = done_cnt;
    do_send(8'hF4);
    wait_rts(lc, dr, ok);
    tick(20);
    dev_clock(11, 1'b1, s);
    tick(10);
    total++; if (!ok || s[7:0] !== 8'hF4 || done_cnt - d0 != 1) begin bad++; $display("FAIL post_reset: got %h done=%0d want f4 1", s[7:0], done_cnt - d0); end
  endtask

  task automatic test_busy_ignore();
    int d0 = done_cnt, lc;
    logic dr; bit ok; logic [9:0] s;
    do_send(8'hA7);
    wait_rts(lc, dr, ok);
    fork
      begin tick(20); dev_clock(11, 1'b1, s); end
      begin tick(200); tx = 8'h55; send = 1'b1; tick(1); send = 1'b0; end
    join
    tick(10);
    total++; if (s[7:0] !== 8'hA7 || s[8] !== odd_par(8'hA7)) begin bad++; $display("FAIL ignore_bits: got %h/%b want a7/%b", s[7:0], s[8], odd_par(8'hA7)); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignore_done: got %0d want 1", done_cnt - d0); end
    tick(INH / 2);
    total++; if (ps2_clk !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ignore_idle: got clk=%b busy=%b want 1 0", ps2_clk, busy); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, lc;
    logic dr; bit ok; logic [9:0] s;
    tx = 8'h12; send = 1'b1;
    tick(1);
    wait_rts(lc, dr, ok);
    tx = 8'h34;
    tick(20);
    dev_clock(11, 1'b1, s);
    total++; if (s[7:0] !== 8'h12 || done_cnt - d0 != 1) begin bad++; $display("FAIL b2b_first: got %h done=%0d want 12 1", s[7:0], done_cnt - d0); end
    total++; if (busy !== 1'b1 || ps2_clk !== 1'b0) begin bad++; $display("FAIL b2b_restart: got busy=%b clk=%b want 1 0", busy, ps2_clk); end
    send = 1'b0;
    wait_rts(lc, dr, ok);
    tick(20);
    dev_clock(11, 1'b1, s);
    tick(10);
    total++; if (!ok || s[7:0] !== 8'h34 || done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_second: got %h done=%0d want 34 2", s[7:0], done_cnt - d0); end
  endtask

  initial begin
    rst_n = 1'b0; send = 1'b0; tx = 8'h00;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_start_timeout();
    test_nack();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
